// File: rtl/cbx_param_shadow.sv
// cbx_param_shadow: horizontal connection block with a double-buffered,
// length-checked configuration chain.
//   - chanx tracks pass straight through (left_in -> right_out, right_in -> left_out).
//   - Each input pin has a MUX_SIZE:1 mux over interleaved left/right tracks.
//   - The serial chain shifts into a shadow register.
//   - The live (active) frame only changes on an accepted load.
//   - A load is accepted only when exactly TOT bits were shifted since the last load.
module cbx_param_shadow #(
    parameter int CHAN_W   = 20,
    parameter int NUM_IPIN = 7,
    parameter int MUX_SIZE = 8,
    parameter int STRIDE   = 6
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                cfg_en,
    input  logic                cfg_load,
    input  logic                ccff_head,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int SEL_W = $clog2(MUX_SIZE);
    localparam int CFG_W = SEL_W + 1;
    localparam int TOT   = NUM_IPIN * CFG_W;
    localparam int CNT_W = $clog2(TOT + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOT);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOT + 1);

    logic [TOT-1:0]   sreg_reg;
    logic [TOT-1:0]   sreg_next;
    logic [TOT-1:0]   active_reg;
    logic [TOT-1:0]   active_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             cfg_valid_reg;
    logic             cfg_valid_next;
    logic             cfg_err_reg;
    logic             cfg_err_next;

    // Next-state for the chain.
    // A shift always wins over a same-cycle load; such a load is rejected.
    // The bit counter saturates at TOT+1, so an over-long frame cannot wrap
    // back around to an accepted length.
    always_comb begin
        sreg_next      = sreg_reg;
        active_next    = active_reg;
        cnt_next       = cnt_reg;
        cfg_valid_next = cfg_valid_reg;
        cfg_err_next   = cfg_err_reg;
        if (cfg_en) begin
            sreg_next = {sreg_reg[TOT-2:0], ccff_head};
            if (cnt_reg != CNT_SAT) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            if (cfg_load) begin
                cfg_err_next = 1'b1;
            end
        end else if (cfg_load) begin
            cnt_next = '0;
            if (cnt_reg == CNT_FULL) begin
                active_next    = sreg_reg;
                cfg_valid_next = 1'b1;
                cfg_err_next   = 1'b0;
            end else begin
                cfg_err_next   = 1'b1;
            end
        end
    end

    // Configuration state registers; asynchronous active-low clear discards any partial frame.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sreg_reg      <= '0;
            active_reg    <= '0;
            cnt_reg       <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            sreg_reg      <= sreg_next;
            active_reg    <= active_next;
            cnt_reg       <= cnt_next;
            cfg_valid_reg <= cfg_valid_next;
            cfg_err_reg   <= cfg_err_next;
        end
    end

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;
    assign ccff_tail       = sreg_reg[TOT-1];
    assign cfg_valid       = cfg_valid_reg;
    assign cfg_err         = cfg_err_reg;

    // One mux per pin.
    // Input pair m taps track (pin + m*STRIDE) mod CHAN_W: the even input
    // takes the left track and the odd input takes the right track.
    generate
        for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
            logic [MUX_SIZE-1:0] mux_in;
            logic [SEL_W-1:0]    sel;
            logic                en;

            for (genvar gj = 0; gj < MUX_SIZE / 2; gj++) begin : g_pair
                localparam int TRK = (gi + gj * STRIDE) % CHAN_W;
                assign mux_in[2*gj]   = chanx_left_in[TRK];
                assign mux_in[2*gj+1] = chanx_right_in[TRK];
            end

            assign sel = active_reg[gi*CFG_W +: SEL_W];
            assign en  = active_reg[gi*CFG_W + SEL_W];

            // Pin output is forced low until a frame is committed or while the pin is disabled.
            always_comb begin
                ipin_out[gi] = cfg_valid_reg & en & mux_in[sel];
            end
        end
    endgenerate

endmodule
